// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, defaults and FSM encodings.
package fetch_ctrl_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned STATE_W      = 3;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF  = 255;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_REQ   = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_LOAD  = 3'd3;
  localparam state_t S_HOLD  = 3'd4;
  localparam state_t S_DRAIN = 3'd5;
  localparam state_t S_ERR   = 3'd6;

endpackage

// File: rtl/fetch_ctrl_timeout_cnt.sv
// RAM-acknowledge watchdog: counts waiting cycles and flags the last cycle before timeout.
module fetch_ctrl_timeout_cnt
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Asserted during the LIMIT-th enabled cycle so the caller can leave on that edge.
  assign o_expired_c = i_en && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads instruction RAM, strobes the IR and hands words to control.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned        PC_STEP  = PC_STEP_DEF,
  parameter int unsigned        TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_ram_req,
  output logic [ADDR_W-1:0]  o_ram_addr,
  input  logic               i_ram_ack,
  input  logic [INSTR_W-1:0] i_ram_rdata,
  output logic [INSTR_W-1:0] o_ir_data,
  output logic               o_ir_load,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [ADDR_W-1:0]  o_pc,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_busy,
  output logic               o_fetch_err
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic                r_ram_req;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [INSTR_W-1:0]  r_ir_data;
  logic                r_ir_load;
  logic                r_instr_valid;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_busy;
  logic                r_fetch_err;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_fetch_pc_nxt;
  logic                w_ram_req_nxt;
  logic [ADDR_W-1:0]   w_ram_addr_nxt;
  logic [INSTR_W-1:0]  w_ir_data_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                w_fetch_err_nxt;
  logic                w_cnt_clr;
  logic                w_cnt_en;
  logic                w_expired;

  fetch_ctrl_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_cnt_clr),
    .i_en        (w_cnt_en),
    .o_expired_c (w_expired)
  );

  assign w_cnt_clr = (r_state == S_REQ);
  assign w_cnt_en  = (r_state == S_WAIT) || (r_state == S_DRAIN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_ram_req     <= 1'b0;
      r_ram_addr    <= RESET_PC;
      r_ir_data     <= '0;
      r_ir_load     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_pc          <= RESET_PC;
      r_busy        <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_ram_req     <= w_ram_req_nxt;
      r_ram_addr    <= w_ram_addr_nxt;
      r_ir_data     <= w_ir_data_nxt;
      r_ir_load     <= (w_state_nxt == S_LOAD);
      r_instr_valid <= (w_state_nxt == S_HOLD);
      r_pc          <= w_pc_nxt;
      r_busy        <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
      r_fetch_err   <= w_fetch_err_nxt;
    end
  end

  // Next state plus the values every registered output takes on entering it.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_ram_req_nxt   = r_ram_req;
    w_ram_addr_nxt  = r_ram_addr;
    w_ir_data_nxt   = r_ir_data;
    w_pc_nxt        = r_pc;
    w_fetch_err_nxt = r_fetch_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (i_redirect) w_fetch_pc_nxt = i_redirect_pc;
        w_state_nxt = i_redirect ? S_REQ : S_WAIT;
      end
      S_WAIT: begin
        if (i_redirect) begin
          w_fetch_pc_nxt = i_redirect_pc;
          w_state_nxt    = i_ram_ack ? S_REQ : S_DRAIN;
        end else if (i_ram_ack) begin
          w_ir_data_nxt = i_ram_rdata;
          w_state_nxt   = S_LOAD;
        end else if (w_expired) begin
          w_fetch_err_nxt = 1'b1;
          w_state_nxt     = S_ERR;
        end
      end
      S_LOAD: begin
        w_pc_nxt = r_fetch_pc;
        if (i_redirect) begin
          w_fetch_pc_nxt = i_redirect_pc;
          w_state_nxt    = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          w_fetch_pc_nxt = i_redirect_pc;
          w_state_nxt    = S_REQ;
        end else if (i_instr_ready) begin
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(PC_STEP);
          w_state_nxt    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_redirect) w_fetch_pc_nxt = i_redirect_pc;
        if (i_ram_ack) begin
          w_state_nxt = S_REQ;
        end else if (w_expired) begin
          w_fetch_err_nxt = 1'b1;
          w_state_nxt     = S_ERR;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // The RAM request is (re)issued only when entering REQ; address stays frozen otherwise.
    if (w_state_nxt == S_REQ) begin
      w_ram_req_nxt  = 1'b1;
      w_ram_addr_nxt = w_fetch_pc_nxt;
    end else if ((w_state_nxt == S_LOAD) || (w_state_nxt == S_ERR)) begin
      w_ram_req_nxt = 1'b0;
    end
  end

  assign o_ram_req     = r_ram_req;
  assign o_ram_addr    = r_ram_addr;
  assign o_ir_data     = r_ir_data;
  assign o_ir_load     = r_ir_load;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_busy        = r_busy;
  assign o_fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then random traffic against a program-order model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ram_req;
  logic [31:0] ram_addr;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic [31:0] ir_data;
  logic        ir_load;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_ram_req     (ram_req),
    .o_ram_addr    (ram_addr),
    .i_ram_ack     (ram_ack),
    .i_ram_rdata   (ram_rdata),
    .o_ir_data     (ir_data),
    .o_ir_load     (ir_load),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_pc          (pc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_busy        (busy),
    .o_fetch_err   (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ram_req"}, 32'(ram_req), 0);
    check({tag, "_ir_load"}, 32'(ir_load), 0);
    check({tag, "_valid"},   32'(instr_valid), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_err"},     32'(fetch_err), 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_pc"},      pc, 0);
    check({tag, "_ir_data"}, ir_data, 0);
  endtask

  // Entered at the negedge of a REQ cycle; RAM acks on the first WAIT cycle.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_req"},  32'(ram_req), 1);
    check({tag, "_addr"}, ram_addr, addr);
    step();
    check({tag, "_wait_addr"}, ram_addr, addr);
    ram_ack = 1'b1; ram_rdata = data;
    step();
    ram_ack = 1'b0; ram_rdata = 32'h0;
    check({tag, "_ir_load"}, 32'(ir_load), 1);
    check({tag, "_ir_data"}, ir_data, data);
    check({tag, "_req_drop"}, 32'(ram_req), 0);
    step();
    check({tag, "_valid"}, 32'(instr_valid), 1);
    check({tag, "_pc"}, pc, addr);
    check({tag, "_ld_once"}, 32'(ir_load), 0);
  endtask

  logic        rb;
  int          rlat;
  int          rcnt;
  logic [31:0] rcap;
  logic        req_start;
  logic [31:0] exp_pc;
  logic [31:0] tmp;
  logic        prev_ir_load;
  logic [31:0] prev_ir_data;
  int          consumed;
  int          n;

  initial begin
    rst = 1'b1; start = 1'b0; ram_ack = 1'b0; ram_rdata = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) step();
    check_reset("rst");

    // First fetch from reset PC
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    serve("t1", 32'h0, 32'h0020_8033);

    // Control unit stalls; no new request may start
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_valid_held", 32'(instr_valid), 1);
      check("t2_no_req", 32'(ram_req), 0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_valid_drop", 32'(instr_valid), 0);
    serve("t2", 32'h4, 32'hDEAD_0004);

    // Redirect during WAIT with late ack drains the old request
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t3_addr8", ram_addr, 32'h8);
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      redirect = 1'b0;
      check("t3_drain_req", 32'(ram_req), 1);
      check("t3_drain_addr", ram_addr, 32'h8);
      check("t3_drain_noload", 32'(ir_load), 0);
    end
    ram_ack = 1'b1; ram_rdata = 32'hBAD0_0008;
    step();
    ram_ack = 1'b0;
    check("t3_noload", 32'(ir_load), 0);
    serve("t3", 32'h100, 32'h1111_0100);

    // Redirect together with ack in WAIT
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t4a_addr", ram_addr, 32'h104);
    step();
    redirect = 1'b1; redirect_pc = 32'h200; ram_ack = 1'b1; ram_rdata = 32'hBAD1_0104;
    step();
    redirect = 1'b0; ram_ack = 1'b0;
    check("t4a_noload", 32'(ir_load), 0);
    step();
    check("t4a_noload2", 32'(ir_load), 0);
    check("t4a_wait_addr", ram_addr, 32'h200);
    step();
    check("t4a_noload3", 32'(ir_load), 0);
    check("t4a_stillreq", 32'(ram_req), 1);
    // Still waiting: replay the REQ-side step by serving from the WAIT cycle
    ram_ack = 1'b1; ram_rdata = 32'h2222_0200;
    step();
    ram_ack = 1'b0;
    check("t4a_ir_load", 32'(ir_load), 1);
    check("t4a_ir_data", ir_data, 32'h2222_0200);
    step();
    check("t4a_pc", pc, 32'h200);

    // Redirect beats instr_ready in HOLD: no PC step
    redirect = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    check("t4b_valid", 32'(instr_valid), 0);
    serve("t4b", 32'h300, 32'h3333_0300);

    // PC wrap, then reset mid-request with a late ack
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    serve("t5", 32'hFFFF_FFFC, 32'h4444_FFFC);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t5_wrap_addr", ram_addr, 32'h0);
    check("t5_wrap_req", 32'(ram_req), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("t5_rst");
    ram_ack = 1'b1; ram_rdata = 32'h5555_5555;
    step();
    ram_ack = 1'b0;
    check("t5_late_noload", 32'(ir_load), 0);
    check("t5_late_idle", 32'(busy), 0);
    check("t5_late_ir", ir_data, 0);

    // RAM never acks
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n = 0;
    while (ram_req === 1'b1 && n < 400) begin
      n++;
      step();
    end
    check("t6_wait_cycles", 32'(n), 255);
    check("t6_err", 32'(fetch_err), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_req", 32'(ram_req), 0);
    start = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    repeat (5) step();
    start = 1'b0; redirect = 1'b0;
    check("t6_sticky_err", 32'(fetch_err), 1);
    check("t6_sticky_busy", 32'(busy), 0);
    check("t6_sticky_req", 32'(ram_req), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("t6_rst");

    // Random traffic: accepted instructions must follow program order from the last redirect
    rb = 1'b0; rlat = 0; rcnt = 0; rcap = 32'h0;
    exp_pc = 32'h0; consumed = 0;
    prev_ir_load = ir_load; prev_ir_data = ir_data;
    start = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (ram_ack) rb = 1'b0;
      ram_ack = 1'b0;
      req_start = 1'b0;
      if (!rb && ram_req) begin
        rb = 1'b1; rcap = ram_addr; rlat = int'($urandom_range(1, 4)); rcnt = 0; req_start = 1'b1;
      end else if (rb) begin
        check("rnd_addr_stable", ram_addr, rcap);
        check("rnd_req_held", 32'(ram_req), 1);
        rcnt++;
        if (rcnt >= rlat) begin
          ram_ack = 1'b1;
          ram_rdata = word_of(rcap);
        end
      end
      if (!ram_ack) ram_rdata = $urandom();

      instr_ready = ($urandom_range(0, 2) != 0);
      redirect = !req_start && ($urandom_range(0, 15) == 0);
      tmp = $urandom();
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (tmp & 32'hC))
                                                 : (tmp & 32'h0000_0FFC);

      if (instr_valid && instr_ready && !redirect) begin
        check("rnd_pc", pc, exp_pc);
        check("rnd_ir_data", ir_data, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect && busy) exp_pc = redirect_pc;

      step();
      check("rnd_load_consec", 32'(prev_ir_load & ir_load), 0);
      check("rnd_ir_data_stable", 32'((ir_data != prev_ir_data) && !ir_load), 0);
      check("rnd_no_err", 32'(fetch_err), 0);
      prev_ir_load = ir_load;
      prev_ir_data = ir_data;
    end
    ram_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0; start = 1'b0;
    check("rnd_progress", 32'(consumed > 50), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
